// File: rtl/ntt_stream_adapter.sv
// Narrow stream to wide NTT-core vector adapter: gathers K-lane beats into P-coefficient
// vectors for the core and serialises each core result vector back into K-lane beats.
module ntt_stream_adapter #(
  parameter int DATA_WIDTH_PER_INPUT = 32,
  parameter int INPUT_PER_CYCLE      = 32,
  parameter int LANES_PER_BEAT       = 1
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            s_valid,
  output logic                                            s_ready,
  input  logic [LANES_PER_BEAT*DATA_WIDTH_PER_INPUT-1:0]  s_data,
  output logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] core_in_data,
  output logic                                            core_in_start,
  input  logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] core_out_data,
  input  logic                                            core_out_start,
  output logic                                            m_valid,
  input  logic                                            m_ready,
  output logic [LANES_PER_BEAT*DATA_WIDTH_PER_INPUT-1:0]  m_data,
  input  logic                                            ovf_clr,
  output logic                                            overflow
);

  localparam int W  = DATA_WIDTH_PER_INPUT;
  localparam int P  = INPUT_PER_CYCLE;
  localparam int K  = LANES_PER_BEAT;
  localparam int B  = P / K;
  localparam int BW = K * W;
  localparam int VW = P * W;
  localparam int CW = (B > 1) ? $clog2(B) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(B - 1);

  typedef enum logic {IN_FILL, IN_ISSUE} in_state_t;
  typedef enum logic {OUT_IDLE, OUT_SEND} out_state_t;

  in_state_t  in_state;
  out_state_t out_state;
  logic [CW-1:0] ib;
  logic [CW-1:0] ob;
  logic [VW-1:0] staging;
  logic [VW-1:0] out_buf;
  logic          s_fire;
  logic          m_fire;
  logic          out_last;

  assign s_fire   = s_valid && s_ready;
  assign m_fire   = m_valid && m_ready;
  assign out_last = m_fire && (ob == LAST_BEAT);

  // The final beat bypasses staging so the full vector lands in core_in_data on its own edge.
  function automatic logic [VW-1:0] complete_vec(input logic [VW-1:0] part,
                                                 input logic [BW-1:0] beat);
    logic [VW-1:0] v;
    v = part;
    v[(B-1)*BW +: BW] = beat;
    return v;
  endfunction

  function automatic logic [BW-1:0] beat_of(input logic [VW-1:0] v, input logic [CW-1:0] idx);
    return v[idx*BW +: BW];
  endfunction

  // NOTE: staging is pure datapath and carries no reset; ib restarts at 0, so every lane
  // is rewritten before a vector is ever published.
  always_ff @(posedge clk) begin
    if (s_fire) staging[ib*BW +: BW] <= s_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_state      <= IN_FILL;
      ib            <= '0;
      s_ready       <= 1'b0;
      core_in_start <= 1'b0;
      core_in_data  <= '0;
    end else begin
      case (in_state)
        IN_FILL: begin
          s_ready       <= 1'b1;
          core_in_start <= 1'b0;
          if (s_fire) begin
            if (ib == LAST_BEAT) begin
              core_in_data  <= complete_vec(staging, s_data);
              ib            <= '0;
              s_ready       <= 1'b0;
              core_in_start <= 1'b1;
              in_state      <= IN_ISSUE;
            end else begin
              ib <= ib + 1'b1;
            end
          end
        end
        IN_ISSUE: begin
          s_ready       <= 1'b1;
          core_in_start <= 1'b0;
          in_state      <= IN_FILL;
        end
        default: in_state <= IN_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_state <= OUT_IDLE;
      out_buf   <= '0;
      ob        <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      overflow  <= 1'b0;
    end else begin
      case (out_state)
        OUT_IDLE: begin
          if (core_out_start) begin
            out_buf   <= core_out_data;
            ob        <= '0;
            m_data    <= beat_of(core_out_data, '0);
            m_valid   <= 1'b1;
            out_state <= OUT_SEND;
          end
        end
        OUT_SEND: begin
          if (out_last) begin
            ob <= '0;
            if (core_out_start) begin
              // A new result arriving exactly on the closing handshake chains seamlessly.
              out_buf <= core_out_data;
              m_data  <= beat_of(core_out_data, '0);
            end else begin
              m_valid   <= 1'b0;
              out_state <= OUT_IDLE;
            end
          end else if (m_fire) begin
            ob     <= ob + 1'b1;
            m_data <= beat_of(out_buf, ob + 1'b1);
          end
        end
        default: out_state <= OUT_IDLE;
      endcase

      if (out_state == OUT_SEND && core_out_start && !out_last) overflow <= 1'b1;
      else if (ovf_clr)                                         overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ntt_stream_adapter.sv
// Directed scenarios on a P=8/K=2/W=16 adapter plus randomized round-trip sweeps on other shapes.
module tb_ntt_stream_adapter;

  localparam int W = 16;
  localparam int P = 8;
  localparam int K = 2;
  localparam int B = P / K;
  localparam int NV = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             s_valid, s_ready;
  logic [K*W-1:0]   s_data;
  logic [P*W-1:0]   core_in_data, core_out_data;
  logic             core_in_start, core_out_start;
  logic             m_valid, m_ready;
  logic [K*W-1:0]   m_data;
  logic             ovf_clr, overflow;

  int n_cmp = 0;
  int n_fail = 0;
  int sweep_done = 0;

  ntt_stream_adapter #(.DATA_WIDTH_PER_INPUT(W), .INPUT_PER_CYCLE(P), .LANES_PER_BEAT(K)) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .core_in_data(core_in_data), .core_in_start(core_in_start),
    .core_out_data(core_out_data), .core_out_start(core_out_start),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .ovf_clr(ovf_clr), .overflow(overflow)
  );

  function automatic logic [P*W-1:0] mk_vec(input int base);
    logic [P*W-1:0] v;
    for (int i = 0; i < P; i++) v[i*W +: W] = W'(base + i);
    return v;
  endfunction

  function automatic logic [K*W-1:0] mk_beat(input int base);
    logic [K*W-1:0] b;
    for (int j = 0; j < K; j++) b[j*W +: W] = W'(base + j);
    return b;
  endfunction

  function automatic int cfg_p(input int g);
    case (g)
      0: return 32;
      1: return 32;
      default: return 16;
    endcase
  endfunction

  function automatic int cfg_k(input int g);
    case (g)
      0: return 1;
      1: return 32;
      default: return 4;
    endcase
  endfunction

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
    n_cmp++; if (core_in_start !== 1'b0) begin n_fail++; $display("FAIL rst_start: got %b want 0", core_in_start); end
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    n_cmp++; if (core_in_data !== '0) begin n_fail++; $display("FAIL rst_core_in_data: got %h want 0", core_in_data); end
    n_cmp++; if (m_data !== '0) begin n_fail++; $display("FAIL rst_m_data: got %h want 0", m_data); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_s_ready: got %b want 1", s_ready); end
  endtask

  task automatic test_fill();
    logic [P*W-1:0] exp_v;
    exp_v = mk_vec(1);
    for (int b = 0; b < B; b++) begin
      @(negedge clk);
      if (b > 0) begin
        n_cmp++; if (core_in_start !== 1'b0) begin n_fail++; $display("FAIL fill_early_start: beat %0d got %b want 0", b, core_in_start); end
      end
      n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL fill_s_ready: beat %0d got %b want 1", b, s_ready); end
      s_valid = 1'b1;
      s_data  = mk_beat(1 + b*K);
    end
    @(negedge clk);
    s_valid = 1'b0;
    n_cmp++; if (core_in_start !== 1'b1) begin n_fail++; $display("FAIL fill_start: got %b want 1", core_in_start); end
    n_cmp++; if (core_in_data !== exp_v) begin n_fail++; $display("FAIL fill_data: got %h want %h", core_in_data, exp_v); end
    n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL fill_issue_ready: got %b want 0", s_ready); end
    @(negedge clk);
    n_cmp++; if (core_in_start !== 1'b0) begin n_fail++; $display("FAIL fill_pulse_len: got %b want 0", core_in_start); end
    n_cmp++; if (core_in_data !== exp_v) begin n_fail++; $display("FAIL fill_hold: got %h want %h", core_in_data, exp_v); end
    n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_back: got %b want 1", s_ready); end
  endtask

  task automatic test_drain();
    int beat;
    @(negedge clk);
    core_out_data  = mk_vec(10);
    core_out_start = 1'b1;
    m_ready        = 1'b0;
    beat = 0;
    for (int cyc = 0; cyc < 16 && beat < B; cyc++) begin
      @(negedge clk);
      core_out_start = 1'b0;
      m_ready = (cyc % 2 == 0);
      n_cmp++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid: cyc %0d got %b want 1", cyc, m_valid); end
      n_cmp++; if (m_data !== mk_beat(10 + beat*K)) begin n_fail++; $display("FAIL drain_data: cyc %0d got %h want %h", cyc, m_data, mk_beat(10 + beat*K)); end
      if (m_ready) beat++;
    end
    n_cmp++; if (beat != B) begin n_fail++; $display("FAIL drain_timeout: drained %0d want %0d", beat, B); end
    @(negedge clk);
    m_ready = 1'b0;
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL drain_idle: got %b want 0", m_valid); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    core_out_data  = mk_vec(20);
    core_out_start = 1'b1;
    m_ready        = 1'b1;
    for (int b = 0; b < B; b++) begin
      @(negedge clk);
      core_out_start = 1'b0;
      n_cmp++; if (m_data !== mk_beat(20 + b*K) || m_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first: beat %0d got %h/%b want %h/1", b, m_data, m_valid, mk_beat(20 + b*K)); end
      if (b == B-1) begin
        core_out_data  = mk_vec(30);
        core_out_start = 1'b1;
      end
    end
    for (int b = 0; b < B; b++) begin
      @(negedge clk);
      core_out_start = 1'b0;
      n_cmp++; if (m_data !== mk_beat(30 + b*K) || m_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second: beat %0d got %h/%b want %h/1", b, m_data, m_valid, mk_beat(30 + b*K)); end
      n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow: beat %0d got %b want 0", b, overflow); end
    end
    @(negedge clk);
    m_ready = 1'b0;
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b want 0", m_valid); end
  endtask

  task automatic test_overflow();
    @(negedge clk);
    core_out_data  = mk_vec(40);
    core_out_start = 1'b1;
    m_ready        = 1'b1;
    @(negedge clk);
    core_out_start = 1'b0;
    n_cmp++; if (m_data !== mk_beat(40)) begin n_fail++; $display("FAIL ovf_beat0: got %h want %h", m_data, mk_beat(40)); end
    @(negedge clk);
    core_out_data  = mk_vec(90);
    core_out_start = 1'b1;
    m_ready        = 1'b0;
    @(negedge clk);
    core_out_start = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow); end
    n_cmp++; if (m_data !== mk_beat(42) || m_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_keep: got %h/%b want %h/1", m_data, m_valid, mk_beat(42)); end
    m_ready = 1'b1;
    for (int b = 2; b < B; b++) begin
      @(negedge clk);
      n_cmp++; if (m_data !== mk_beat(40 + b*K)) begin n_fail++; $display("FAIL ovf_rest: beat %0d got %h want %h", b, m_data, mk_beat(40 + b*K)); end
    end
    @(negedge clk);
    m_ready = 1'b0;
    n_cmp++; if (m_valid !== 1'b0 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_end: got valid %b ovf %b want 0/1", m_valid, overflow); end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow); end

    core_out_data  = mk_vec(60);
    core_out_start = 1'b1;
    @(negedge clk);
    core_out_data  = mk_vec(99);
    ovf_clr        = 1'b1;
    @(negedge clk);
    core_out_start = 1'b0;
    ovf_clr        = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_priority: got %b want 1", overflow); end
    m_ready = 1'b1;
    for (int b = 0; b < B; b++) begin
      n_cmp++; if (m_data !== mk_beat(60 + b*K)) begin n_fail++; $display("FAIL ovf_prio_data: beat %0d got %h want %h", b, m_data, mk_beat(60 + b*K)); end
      @(negedge clk);
    end
    m_ready = 1'b0;
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    n_cmp++; if (overflow !== 1'b0 || m_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_final: got ovf %b valid %b want 0/0", overflow, m_valid); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(negedge clk);
    core_out_data  = mk_vec(70);
    core_out_start = 1'b1;
    @(negedge clk);
    core_out_start = 1'b0;
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = mk_beat(200);
    @(negedge clk);
    m_ready = 1'b0;
    s_data  = mk_beat(202);
    @(negedge clk);
    s_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (s_ready !== 1'b0 || core_in_start !== 1'b0) begin n_fail++; $display("FAIL mid_rst_in: got ready %b start %b want 0/0", s_ready, core_in_start); end
    n_cmp++; if (m_valid !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out: got valid %b ovf %b want 0/0", m_valid, overflow); end
    n_cmp++; if (core_in_data !== '0) begin n_fail++; $display("FAIL mid_rst_cid: got %h want 0", core_in_data); end
    n_cmp++; if (m_data !== '0) begin n_fail++; $display("FAIL mid_rst_mdata: got %h want 0", m_data); end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (core_in_start === 1'b1) begin
        pulses++;
        n_cmp++; if (core_in_data !== mk_vec(300)) begin n_fail++; $display("FAIL mid_fresh_data: got %h want %h", core_in_data, mk_vec(300)); end
      end
      s_valid = (c < B);
      s_data  = mk_beat(300 + c*K);
    end
    n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL mid_pulses: got %0d want 1", pulses); end
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_output: got %b want 0", m_valid); end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int GP = cfg_p(g);
    localparam int GK = cfg_k(g);
    localparam int GB = GP / GK;

    logic              rst_g, s_valid_g, s_ready_g, cis_g, cos_g, m_valid_g, m_ready_g, ovf_g;
    logic [GK*W-1:0]   s_data_g, m_data_g;
    logic [GP*W-1:0]   cid_g, cod_g;

    ntt_stream_adapter #(.DATA_WIDTH_PER_INPUT(W), .INPUT_PER_CYCLE(GP), .LANES_PER_BEAT(GK)) u_dut (
      .clk(clk), .rst(rst_g), .s_valid(s_valid_g), .s_ready(s_ready_g), .s_data(s_data_g),
      .core_in_data(cid_g), .core_in_start(cis_g),
      .core_out_data(cod_g), .core_out_start(cos_g),
      .m_valid(m_valid_g), .m_ready(m_ready_g), .m_data(m_data_g),
      .ovf_clr(1'b0), .overflow(ovf_g)
    );

    initial begin
      logic [W-1:0]    coef_q[$];
      logic [W-1:0]    out_q[$];
      logic [GP*W-1:0] core_q[$];
      logic [GP*W-1:0] ev;
      logic [GK*W-1:0] eb;
      int beats_in, beats_out, pulses;
      beats_in = 0; beats_out = 0; pulses = 0;
      rst_g = 1'b1; s_valid_g = 1'b0; s_data_g = '0; cos_g = 1'b0; cod_g = '0; m_ready_g = 1'b0;
      #3;
      repeat (3) @(negedge clk);
      rst_g = 1'b0;
      for (int cyc = 0; cyc < 6000 && beats_out < NV*GB; cyc++) begin
        @(negedge clk);
        if (cis_g === 1'b1) begin
          pulses++;
          n_cmp++;
          if (coef_q.size() < GP) begin
            n_fail++; $display("FAIL sweep%0d_extra_start: only %0d coefficients pending", g, coef_q.size());
          end else begin
            for (int i = 0; i < GP; i++) ev[i*W +: W] = coef_q.pop_front();
            if (cid_g !== ev) begin n_fail++; $display("FAIL sweep%0d_vec: got %h want %h", g, cid_g, ev); end
            core_q.push_back(ev);
          end
        end
        cos_g = 1'b0;
        if (m_valid_g !== 1'b1 && core_q.size() > 0) begin
          cod_g = core_q.pop_front();
          cos_g = 1'b1;
          for (int i = 0; i < GP; i++) out_q.push_back(cod_g[i*W +: W]);
        end
        m_ready_g = 1'($urandom_range(0, 1));
        if (m_valid_g === 1'b1 && m_ready_g) begin
          n_cmp++;
          beats_out++;
          if (out_q.size() < GK) begin
            n_fail++; $display("FAIL sweep%0d_extra_beat: got %h with nothing expected", g, m_data_g);
          end else begin
            for (int j = 0; j < GK; j++) eb[j*W +: W] = out_q.pop_front();
            if (m_data_g !== eb) begin n_fail++; $display("FAIL sweep%0d_beat: got %h want %h", g, m_data_g, eb); end
          end
        end
        s_valid_g = 1'b0;
        if (beats_in < NV*GB) begin
          s_valid_g = ($urandom_range(0, 3) != 0);
          for (int j = 0; j < GK; j++) s_data_g[j*W +: W] = W'($urandom);
          if (s_valid_g && s_ready_g === 1'b1) begin
            beats_in++;
            for (int j = 0; j < GK; j++) coef_q.push_back(s_data_g[j*W +: W]);
          end
        end
      end
      n_cmp++; if (beats_out != NV*GB) begin n_fail++; $display("FAIL sweep%0d_drain: got %0d beats want %0d", g, beats_out, NV*GB); end
      n_cmp++; if (pulses != NV) begin n_fail++; $display("FAIL sweep%0d_pulses: got %0d want %0d", g, pulses, NV); end
      n_cmp++; if (ovf_g !== 1'b0) begin n_fail++; $display("FAIL sweep%0d_overflow: got %b want 0", g, ovf_g); end
      s_valid_g = 1'b0;
      m_ready_g = 1'b0;
      sweep_done++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; s_valid = 1'b0; s_data = '0; core_out_data = '0; core_out_start = 1'b0;
    m_ready = 1'b0; ovf_clr = 1'b0;
    #2 rst = 1'b1;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    for (int t = 0; t < 20000 && sweep_done < 3; t++) @(negedge clk);
    n_cmp++; if (sweep_done != 3) begin n_fail++; $display("FAIL sweep_timeout: got %0d done want 3", sweep_done); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
